string_generator_moore: RTL and testbench

//  Serial bit-string transmitter: the source end of the serial 1-bit stream examined by the

---
 rtl/string_generator_moore_if.sv | 32 +++
 rtl/string_generator_moore.sv | 141 ++++++++++++++
 tb/tb_string_generator_moore.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/string_generator_moore_if.sv
`default_nettype none
// ============================================================================
//  Module      : string_generator_moore_if
//  Description : Handshake/serial bundle between a word source (master) and
//                the serial bit-string transmitter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface string_generator_moore_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             out;
    logic             valid;
    logic             bit_tick;
    logic             done;
    logic [7:0]       run_len;

    // Word source: requests transmission and watches the stream.
    modport master (
        output start, data,
        input  ready, out, valid, bit_tick, done, run_len
    );

    // Transmitter: accepts words and produces the stream.
    modport slave (
        input  start, data,
        output ready, out, valid, bit_tick, done, run_len
    );
endinterface
`default_nettype wire

// File: rtl/string_generator_moore.sv
`default_nettype none
// ============================================================================
//  Module      : string_generator_moore
//  Description : Serial bit-string transmitter. Captures a WIDTH-bit word on
//                a start handshake and shifts it out MSB-first, each bit held
//                DIV clocks, with valid/bit_tick/done strobes and a running
//                count of consecutive ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module string_generator_moore #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    string_generator_moore_if.slave         bus
);

    localparam int               C_BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_BCW-1:0] C_LAST_BIT = C_BCW'(WIDTH - 1);
    localparam logic [7:0]       C_DIV_LAST = 8'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state,    w_state_n;
    logic [WIDTH-1:0]   r_shreg,    w_shreg_n;
    logic [C_BCW-1:0]   r_bit_cnt,  w_bit_cnt_n;
    logic [7:0]         r_div_cnt,  w_div_cnt_n;

    // Outputs are flops loaded from the next-state decode, so they change
    // on the same edge as the state they describe and never glitch.
    logic               r_ready,    w_ready_n;
    logic               r_out,      w_out_n;
    logic               r_valid,    w_valid_n;
    logic               r_bit_tick, w_bit_tick_n;
    logic               r_done,     w_done_n;
    logic [7:0]         r_run_len,  w_run_len_n;

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_ready    <= 1'b1;
            r_out      <= 1'b0;
            r_valid    <= 1'b0;
            r_bit_tick <= 1'b0;
            r_done     <= 1'b0;
            r_run_len  <= '0;
        end else begin
            r_state    <= w_state_n;
            r_shreg    <= w_shreg_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_div_cnt  <= w_div_cnt_n;
            r_ready    <= w_ready_n;
            r_out      <= w_out_n;
            r_valid    <= w_valid_n;
            r_bit_tick <= w_bit_tick_n;
            r_done     <= w_done_n;
            r_run_len  <= w_run_len_n;
        end
    end

    // Next-state, shift/count datapath and next-output decode.
    always_comb begin
        w_state_n   = r_state;
        w_shreg_n   = r_shreg;
        w_bit_cnt_n = r_bit_cnt;
        w_div_cnt_n = r_div_cnt;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_n   = S_SHIFT;
                    w_shreg_n   = bus.data;
                    w_bit_cnt_n = '0;
                    w_div_cnt_n = '0;
                end
            end
            S_SHIFT: begin
                if (r_div_cnt == C_DIV_LAST) begin
                    w_div_cnt_n = '0;
                    if (r_bit_cnt == C_LAST_BIT) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_shreg_n   = r_shreg << 1;
                        w_bit_cnt_n = r_bit_cnt + C_BCW'(1);
                    end
                end else begin
                    w_div_cnt_n = r_div_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_state_n   = S_IDLE;
                w_shreg_n   = '0;
                w_bit_cnt_n = '0;
                w_div_cnt_n = '0;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_ready_n    = (w_state_n == S_IDLE);
        w_valid_n    = (w_state_n == S_SHIFT);
        w_done_n     = (w_state_n == S_DONE);
        w_out_n      = w_valid_n & w_shreg_n[WIDTH-1];
        w_bit_tick_n = w_valid_n && (w_div_cnt_n == 8'd0);

        // Run length only moves on a bit boundary; a fresh frame starts from 0.
        w_run_len_n = '0;
        if (w_valid_n) begin
            if (!w_bit_tick_n) begin
                w_run_len_n = r_run_len;
            end else if (w_out_n) begin
                if (r_state == S_IDLE) begin
                    w_run_len_n = 8'd1;
                end else if (r_run_len == 8'hFF) begin
                    w_run_len_n = 8'hFF;
                end else begin
                    w_run_len_n = r_run_len + 8'd1;
                end
            end
        end
    end

    assign bus.ready    = r_ready;
    assign bus.out      = r_out;
    assign bus.valid    = r_valid;
    assign bus.bit_tick = r_bit_tick;
    assign bus.done     = r_done;
    assign bus.run_len  = r_run_len;

endmodule
`default_nettype wire

// File: tb/tb_string_generator_moore.sv
`default_nettype none
// ============================================================================
//  Module      : tb_string_generator_moore
//  Description : Self-checking bench for string_generator_moore (DIV=4 and
//                DIV=1 instances) using a per-clock expected-sample queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_string_generator_moore;

    typedef struct packed {
        logic       out;
        logic       valid;
        logic       tick;
        logic       done;
        logic       ready;
        logic [7:0] run;
    } exp_t;

    localparam exp_t C_IDLE = '{out: 1'b0, valid: 1'b0, tick: 1'b0, done: 1'b0, ready: 1'b1, run: 8'd0};
    localparam exp_t C_DONE = '{out: 1'b0, valid: 1'b0, tick: 1'b0, done: 1'b1, ready: 1'b0, run: 8'd0};

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t q_exp[$];
    exp_t e;
    exp_t obs;

    string_generator_moore_if #(.WIDTH(8)) bus4 ();
    string_generator_moore_if #(.WIDTH(8)) bus1 ();

    string_generator_moore #(.WIDTH(8), .DIV(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    string_generator_moore #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t obs4();
        return '{bus4.out, bus4.valid, bus4.bit_tick, bus4.done, bus4.ready, bus4.run_len};
    endfunction

    function automatic exp_t obs1();
        return '{bus1.out, bus1.valid, bus1.bit_tick, bus1.done, bus1.ready, bus1.run_len};
    endfunction

    // Expected samples for one whole frame, the DONE clock and the IDLE clock.
    function automatic void push_frame(input logic [7:0] d, input int div);
        int   run;
        logic b;
        exp_t x;
        run = 0;
        for (int k = 0; k < 8; k++) begin
            b   = d[7-k];
            run = b ? ((run < 255) ? run + 1 : 255) : 0;
            for (int j = 0; j < div; j++) begin
                x = '{out: b, valid: 1'b1, tick: (j == 0), done: 1'b0, ready: 1'b0, run: 8'(run)};
                q_exp.push_back(x);
            end
        end
        q_exp.push_back(C_DONE);
        q_exp.push_back(C_IDLE);
    endfunction

    task automatic test_reset();
        // Power-on reset values on both instances.
        @(negedge clk);
        n_checks++;
        if (obs4() !== C_IDLE) begin
            n_fail++;
            $display("FAIL reset_init4 got=%h exp=%h", obs4(), C_IDLE);
        end
        n_checks++;
        if (obs1() !== C_IDLE) begin
            n_fail++;
            $display("FAIL reset_init1 got=%h exp=%h", obs1(), C_IDLE);
        end
        rst_n = 1'b1;
        // Start an all-ones frame and abort it mid-way.
        @(negedge clk);
        bus4.data  = 8'hFF;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if (bus4.valid !== 1'b1 || bus4.out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midframe_active got valid=%b out=%b exp valid=1 out=1", bus4.valid, bus4.out);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs4() !== C_IDLE) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=%h", obs4(), C_IDLE);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // No done pulse and no resumed frame after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs4() !== C_IDLE) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, obs4(), C_IDLE);
            end
        end
    endtask

    task automatic test_pattern_b7();
        int idx;
        push_frame(8'hB7, 4);
        bus4.data  = 8'hB7;
        bus4.start = 1'b1;
        idx = 0;
        while (q_exp.size() > 0) begin
            @(negedge clk);
            e   = q_exp.pop_front();
            obs = obs4();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL pattern_b7 idx=%0d got=%h exp=%h", idx, obs, e);
            end
            if (idx == 0) begin
                bus4.start = 1'b0;
                bus4.data  = 8'h00;
            end
            idx++;
        end
    endtask

    task automatic test_ignore_start();
        int idx;
        push_frame(8'hC3, 4);
        q_exp.push_back(C_IDLE);
        bus4.data  = 8'hC3;
        bus4.start = 1'b1;
        idx = 0;
        while (q_exp.size() > 0) begin
            @(negedge clk);
            e   = q_exp.pop_front();
            obs = obs4();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL ignore_start idx=%0d got=%h exp=%h", idx, obs, e);
            end
            if (idx == 0)  bus4.start = 1'b0;
            if (idx == 10) begin
                bus4.start = 1'b1;
                bus4.data  = 8'h00;
            end
            if (idx == 11) bus4.start = 1'b0;
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        push_frame(8'hA5, 4);
        push_frame(8'h5A, 4);
        bus4.data  = 8'hA5;
        bus4.start = 1'b1;
        idx = 0;
        while (q_exp.size() > 0) begin
            @(negedge clk);
            e   = q_exp.pop_front();
            obs = obs4();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back idx=%0d got=%h exp=%h", idx, obs, e);
            end
            if (idx == 0) bus4.data = 8'h5A;
            // Drop start once the second frame's DONE has been seen.
            if (q_exp.size() == 1) bus4.start = 1'b0;
            idx++;
        end
    endtask

    task automatic test_div1_ones();
        int idx;
        int det_run;
        int det_cnt;
        int det_first;
        push_frame(8'hFF, 1);
        bus1.data  = 8'hFF;
        bus1.start = 1'b1;
        idx       = 0;
        det_run   = 0;
        det_cnt   = 0;
        det_first = -1;
        while (q_exp.size() > 0) begin
            @(negedge clk);
            e   = q_exp.pop_front();
            obs = obs1();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL div1_ones idx=%0d got=%h exp=%h", idx, obs, e);
            end
            // Run-of-ones detector (three or more) fed from the serial line.
            if (obs.valid && obs.out) det_run++;
            else                      det_run = 0;
            if (det_run >= 3) begin
                det_cnt++;
                if (det_first < 0) det_first = idx;
            end
            if (idx == 0) bus1.start = 1'b0;
            idx++;
        end
        n_checks++;
        if (det_cnt !== 6 || det_first !== 2) begin
            n_fail++;
            $display("FAIL div1_detector got cnt=%0d first=%0d exp cnt=6 first=2", det_cnt, det_first);
        end
    endtask

    task automatic test_zero();
        int idx;
        push_frame(8'h00, 4);
        bus4.data  = 8'h00;
        bus4.start = 1'b1;
        idx = 0;
        while (q_exp.size() > 0) begin
            @(negedge clk);
            e   = q_exp.pop_front();
            obs = obs4();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL zero_word idx=%0d got=%h exp=%h", idx, obs, e);
            end
            if (idx == 0) bus4.start = 1'b0;
            idx++;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus4.start = 1'b0;
        bus4.data  = '0;
        bus1.start = 1'b0;
        bus1.data  = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_pattern_b7();
        test_ignore_start();
        test_back_to_back();
        test_div1_ones();
        test_zero();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
